// File: rtl/led_counter_gen_if.sv
// Control/status bundle for led_counter_gen. The slave modport is the
// counter's view of the bundle; the master modport is the controller's view.
interface led_counter_gen_if #(
  parameter int WIDTH = 8
);
  logic             ipEnable;
  logic [1:0]       ipMode;
  logic             ipLoad;
  logic [WIDTH-1:0] ipLoadValue;
  logic [WIDTH-1:0] opLED;
  logic             opTick;
  logic             opWrap;

  modport master (
    output ipEnable, ipMode, ipLoad, ipLoadValue,
    input  opLED, opTick, opWrap
  );

  modport slave (
    input  ipEnable, ipMode, ipLoad, ipLoadValue,
    output opLED, opTick, opWrap
  );
endinterface

// File: rtl/led_counter_gen.sv
// Prescaled LED counter with up/down/ping-pong/hold modes, synchronous load,
// and tick/wrap pulses. Define LED_COUNTER_GRAY_EN to drive opLED in Gray code.
module led_counter_gen #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic               ipClk,
  input  logic               ipReset,
  led_counter_gen_if.slave   bus
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]      CNT_MAX = '1;
  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      led_q, led_d;
  dir_e                  dir_q, dir_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  step;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    step    = 1'b0;
    if (bus.ipLoad) begin
      cnt_d   = bus.ipLoadValue;
      presc_d = '0;
    end else if (bus.ipEnable) begin
      step    = (presc_q == PS_LAST);
      presc_d = step ? '0 : presc_q + PRESCALE_W'(1);
      tick_d  = step;
      // Direction follows the mode every enabled cycle so ping-pong starts in the prior heading
      case (mode_e'(bus.ipMode))
        MODE_UP: begin
          dir_d = DIR_UP;
          if (step) begin
            cnt_d  = cnt_q + WIDTH'(1);
            wrap_d = (cnt_q == CNT_MAX);
          end
        end
        MODE_DOWN: begin
          dir_d = DIR_DOWN;
          if (step) begin
            cnt_d  = cnt_q - WIDTH'(1);
            wrap_d = (cnt_q == '0);
          end
        end
        MODE_PING: begin
          if (step) begin
            if (dir_q == DIR_UP) begin
              if (cnt_q == CNT_MAX) begin
                cnt_d  = CNT_MAX - WIDTH'(1);
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q + WIDTH'(1);
              end
            end else begin
              if (cnt_q == '0) begin
                cnt_d  = WIDTH'(1);
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                cnt_d = cnt_q - WIDTH'(1);
              end
            end
          end
        end
        default: dir_d = DIR_UP;
      endcase
    end
  end

`ifdef LED_COUNTER_GRAY_EN
  always_comb led_d = cnt_d ^ (cnt_d >> 1);
`else
  always_comb led_d = cnt_d;
`endif

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.opLED  = led_q;
  assign bus.opTick = tick_q;
  assign bus.opWrap = wrap_q;

endmodule
